// File: rtl/data_mem_unit_if.sv
// Memory-stage data interface between the memory stage (master) and the data
// memory unit (slave).
//   i_req      request strobe (sampled only while the responder is idle)
//   i_write    1 = store/push, 0 = load/pop
//   i_en32     1 = 32-bit access (two words), 0 = 16-bit
//   i_isStack  1 = push/pop through SP; i_addr ignored
//   i_addr     word address for non-stack accesses
//   i_wdata    store data; 16-bit stores use [15:0]
//   o_busy     responder not idle
//   o_valid    one-cycle completion pulse
//   o_rdata    load result, held until the next load completes
//   o_sp       current stack pointer
interface data_mem_unit_if #(
  parameter int unsigned ADDR_W = 11
);
  logic              i_req;
  logic              i_write;
  logic              i_en32;
  logic              i_isStack;
  logic [15:0]       i_addr;
  logic [31:0]       i_wdata;
  logic              o_busy;
  logic              o_valid;
  logic [31:0]       o_rdata;
  logic [ADDR_W-1:0] o_sp;

  modport master (
    output i_req, i_write, i_en32, i_isStack, i_addr, i_wdata,
    input  o_busy, o_valid, o_rdata, o_sp
  );

  modport slave (
    input  i_req, i_write, i_en32, i_isStack, i_addr, i_wdata,
    output o_busy, o_valid, o_rdata, o_sp
  );
endinterface

// File: rtl/data_mem_unit.sv
// Data memory unit: responder for memory-stage load/store and push/pop requests.
// Owns a 2**ADDR_W x 16-bit data memory and the stack pointer. Each 32-bit access
// is split into two sequential 16-bit word accesses (W0, then W1).
//   clk   rising-edge clock
//   rst   synchronous, active-high reset (priority over everything)
//   bus   data_mem_unit_if slave modport (request in, busy/valid/rdata/sp out)
module data_mem_unit #(
  parameter int unsigned       ADDR_W   = 11,
  parameter logic [ADDR_W-1:0] SP_RESET = {ADDR_W{1'b1}}
) (
  input  logic           clk,
  input  logic           rst,
  data_mem_unit_if.slave bus
);

  localparam int unsigned       Depth = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] One   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] Two   = ADDR_W'(2);

  typedef enum logic [1:0] {StIdle, StW0, StW1, StResp} state_e;

  state_e r_state;
  state_e w_state_d;

  // Request captured on acceptance
  logic              r_write;
  logic              r_en32;
  logic              r_stack;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;

  logic [ADDR_W-1:0] r_sp;
  logic [31:0]       r_rdata;
  logic [15:0]       r_lo;
  logic [15:0]       r_mem [Depth];

  logic              w_accept;
  logic [ADDR_W-1:0] w_base;
  logic [ADDR_W-1:0] w_second;
  logic [ADDR_W-1:0] w_delta;
  logic              w_last;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [15:0]       w_mem_wdata;
  logic [ADDR_W-1:0] w_sp_d;

  logic w_unused_addr;
  assign w_unused_addr = ^bus.i_addr[15:ADDR_W];

  assign w_accept = (r_state == StIdle) && bus.i_req;

  // Push writes at SP and grows down; pop reads from SP+1 and grows up.
  always_comb begin
    w_base   = r_addr;
    w_second = r_addr + One;
    if (r_stack) begin
      if (r_write) begin
        w_base   = r_sp;
        w_second = r_sp - One;
      end else begin
        w_base   = r_sp + One;
        w_second = r_sp + Two;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_last      = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_addr  = w_base;
    w_mem_wdata = r_wdata[15:0];
    unique case (r_state)
      StIdle: begin
        if (bus.i_req) begin
          w_state_d = StW0;
        end
      end
      StW0: begin
        w_mem_we = r_write;
        // Push32 stores the high half first, at the higher address
        if (r_stack && r_en32) begin
          w_mem_wdata = r_wdata[31:16];
        end
        w_last    = !r_en32;
        w_state_d = r_en32 ? StW1 : StResp;
      end
      StW1: begin
        w_mem_we    = r_write;
        w_mem_addr  = w_second;
        w_mem_wdata = r_stack ? r_wdata[15:0] : r_wdata[31:16];
        w_last      = 1'b1;
        w_state_d   = StResp;
      end
      StResp: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
    // Reset aborts the access of this cycle
    if (rst) begin
      w_mem_we = 1'b0;
    end
  end

  assign w_delta = r_en32 ? Two : One;

  always_comb begin
    w_sp_d = r_sp;
    if (w_last && r_stack) begin
      w_sp_d = r_write ? (r_sp - w_delta) : (r_sp + w_delta);
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_write <= 1'b0;
      r_en32  <= 1'b0;
      r_stack <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_sp    <= SP_RESET;
      r_rdata <= '0;
      r_lo    <= '0;
    end else begin
      r_sp <= w_sp_d;
      if (w_accept) begin
        r_write <= bus.i_write;
        r_en32  <= bus.i_en32;
        r_stack <= bus.i_isStack;
        r_addr  <= bus.i_addr[ADDR_W-1:0];
        r_wdata <= bus.i_wdata;
      end
      // Synchronous read: result lands on the edge leaving the word state
      if (r_state == StW0 && !r_write) begin
        if (r_en32) begin
          r_lo <= r_mem[w_mem_addr];
        end else begin
          r_rdata <= {16'h0000, r_mem[w_mem_addr]};
        end
      end
      if (r_state == StW1 && !r_write) begin
        r_rdata <= {r_mem[w_mem_addr], r_lo};
      end
    end
  end

  assign bus.o_busy  = (r_state != StIdle);
  assign bus.o_valid = (r_state == StResp);
  assign bus.o_rdata = r_rdata;
  assign bus.o_sp    = r_sp;

endmodule

// File: tb/tb_data_mem_unit.sv
// Scoreboard bench for data_mem_unit: requests update a behavioural memory/SP
// model and push the expected response; a monitor checks each o_valid pulse.
module tb_data_mem_unit;
  localparam int unsigned AW = 11;

  typedef struct {
    logic [31:0]   rd;
    logic [AW-1:0] sp;
    int            cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_mem_unit_if #(.ADDR_W(AW)) bus ();

  data_mem_unit #(.ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t          sb[$];
  logic [15:0]   mdl_mem [2048];
  logic [AW-1:0] mdl_sp;
  logic [31:0]   mdl_rd;
  int            n_vec = 0;
  int            n_err = 0;
  int            cyc = 0;
  logic          prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (prev_valid) chk("busy_after_resp", 32'(bus.o_busy), 32'd0);
    if (bus.o_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("rdata", bus.o_rdata, e.rd);
        chk("sp", 32'(bus.o_sp), 32'(e.sp));
        chk("latency", cyc, e.cyc);
      end
    end
    prev_valid = (bus.o_valid === 1'b1);
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (bus.o_busy !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mdl_sp = 11'h7FF;
    mdl_rd = 32'h0;
  endtask

  // Drive one request from an idle negedge and record its expected response
  task automatic issue(input logic wr, input logic e32, input logic stk,
                       input logic [15:0] addr, input logic [31:0] wd);
    exp_t          e;
    logic [AW-1:0] a;
    wait_idle();
    bus.i_req     = 1'b1;
    bus.i_write   = wr;
    bus.i_en32    = e32;
    bus.i_isStack = stk;
    bus.i_addr    = addr;
    bus.i_wdata   = wd;
    a = addr[AW-1:0];
    if (stk && wr) begin
      if (e32) begin
        mdl_mem[mdl_sp]         = wd[31:16];
        mdl_mem[mdl_sp - 11'd1] = wd[15:0];
        mdl_sp                  = mdl_sp - 11'd2;
      end else begin
        mdl_mem[mdl_sp] = wd[15:0];
        mdl_sp          = mdl_sp - 11'd1;
      end
    end else if (stk) begin
      if (e32) begin
        mdl_rd = {mdl_mem[mdl_sp + 11'd2], mdl_mem[mdl_sp + 11'd1]};
        mdl_sp = mdl_sp + 11'd2;
      end else begin
        mdl_rd = {16'h0, mdl_mem[mdl_sp + 11'd1]};
        mdl_sp = mdl_sp + 11'd1;
      end
    end else if (wr) begin
      mdl_mem[a] = wd[15:0];
      if (e32) mdl_mem[a + 11'd1] = wd[31:16];
    end else begin
      mdl_rd = e32 ? {mdl_mem[a + 11'd1], mdl_mem[a]} : {16'h0, mdl_mem[a]};
    end
    e.rd  = mdl_rd;
    e.sp  = mdl_sp;
    e.cyc = cyc + 1 + (e32 ? 2 : 1);
    sb.push_back(e);
    @(posedge clk);
    #1 bus.i_req = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] a;
    logic [AW-1:0] off;
    int            n;
    rst           = 1'b1;
    bus.i_req     = 1'b0;
    bus.i_write   = 1'b0;
    bus.i_en32    = 1'b0;
    bus.i_isStack = 1'b0;
    bus.i_addr    = 16'h0;
    bus.i_wdata   = 32'h0;
    do_reset();

    // T1: reset state
    @(negedge clk);
    chk("rst_busy", 32'(bus.o_busy), 32'd0);
    chk("rst_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_rdata", bus.o_rdata, 32'h0);
    chk("rst_sp", 32'(bus.o_sp), 32'h7FF);

    // Known contents for the 64-word window 0x7F0..0x02F used below
    for (int i = 0; i < 64; i++) begin
      a = 11'h7F0 + 11'(i);
      issue(1'b1, 1'b0, 1'b0, {5'h0, a}, $urandom);
    end

    // T2: store16 / load16
    issue(1'b1, 1'b0, 1'b0, 16'h0010, 32'h0000BEEF);
    issue(1'b0, 1'b0, 1'b0, 16'h0010, 32'h0);

    // T3: store32 wrapping the top of memory, then read back
    issue(1'b1, 1'b1, 1'b0, 16'h07FF, 32'h12345678);
    issue(1'b0, 1'b1, 1'b0, 16'h07FF, 32'h0);
    issue(1'b0, 1'b0, 1'b0, 16'h0000, 32'h0);
    issue(1'b0, 1'b0, 1'b0, 16'hF7FF, 32'h0);

    // T4: push32 / pop32 / pop16 from reset
    wait_idle();
    do_reset();
    issue(1'b1, 1'b1, 1'b1, 16'h1234, 32'hCAFEF00D);
    issue(1'b0, 1'b0, 1'b0, 16'h07FE, 32'h0);
    issue(1'b0, 1'b1, 1'b1, 16'h0000, 32'h0);
    issue(1'b0, 1'b0, 1'b1, 16'h0000, 32'h0);

    // T5: second request during W0 is dropped
    issue(1'b0, 1'b0, 1'b0, 16'h0010, 32'h0);
    bus.i_req = 1'b1;
    @(posedge clk);
    #1 bus.i_req = 1'b0;

    // T6: reset in W1 of a store32
    wait_idle();
    bus.i_req     = 1'b1;
    bus.i_write   = 1'b1;
    bus.i_en32    = 1'b1;
    bus.i_isStack = 1'b0;
    bus.i_addr    = 16'h0020;
    bus.i_wdata   = 32'hAAAA5555;
    @(posedge clk);
    #1 bus.i_req = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    mdl_mem[11'h020] = 16'h5555;
    mdl_sp = 11'h7FF;
    mdl_rd = 32'h0;
    @(negedge clk);
    chk("abort_busy", 32'(bus.o_busy), 32'd0);
    chk("abort_sp", 32'(bus.o_sp), 32'h7FF);
    chk("abort_rdata", bus.o_rdata, 32'h0);
    issue(1'b0, 1'b0, 1'b0, 16'h0021, 32'h0);
    issue(1'b0, 1'b0, 1'b0, 16'h0020, 32'h0);

    // Random mix inside the known window
    for (int i = 0; i < 300; i++) begin
      n = int'($urandom_range(0, 3));
      if (n < 2) begin
        a = 11'h7F0 + 11'($urandom_range(0, 62));
        issue(n == 0, 1'($urandom), 1'b0, {5'($urandom), a}, $urandom);
      end else begin
        off = mdl_sp - 11'h7F0;
        if (off < 11'd4) n = 3;
        else if (off > 11'd58) n = 2;
        issue(n == 2, 1'($urandom), 1'b1, 16'($urandom), $urandom);
      end
    end

    // Drain
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) chk("missing_valid", 32'(sb.size()), 32'd0);
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
